// File: rtl/cond_pkg.sv
// Shared types for the SIMD conditional unit: condition codes, NZCV bit positions
// and the condition evaluator used by every lane.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  function automatic logic cond_eval(input cond_e cond, input flags_t flags);
    logic n, z, c, v;
    logic res;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    res = 1'b0;
    case (cond)
      EQ: res = z;
      NE: res = ~z;
      CS: res = c;
      CC: res = ~c;
      MI: res = n;
      PL: res = ~n;
      VS: res = v;
      VC: res = ~v;
      HI: res = c & ~z;
      LS: res = ~c | z;
      GE: res = (n == v);
      LT: res = (n != v);
      GT: res = ~z & (n == v);
      LE: res = z | (n != v);
      AL: res = 1'b1;
      NV: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/simd_conditional_unit_if.sv
// E-stage control bundle of the SIMD conditional unit.
// The performance counters appear only when COND_PERF_CNT_EN is defined.
interface simd_conditional_unit_if #(
  parameter int LANES = 4
);
  logic                 StallE;
  logic                 FlushE;
  logic                 BranchE;
  logic                 PCSrcE;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic [1:0]           FlagWriteE;
  logic [3:0]           CondE;
  logic [LANES-1:0]     LaneMaskE;
  logic [LANES*4-1:0]   ALUFlagsE;

  logic                 BranchTakenE;
  logic                 PCSrcECU;
  logic                 MemWriteECU;
  logic [LANES-1:0]     RegWriteECU;
  logic [LANES*4-1:0]   FlagsQ;

`ifdef COND_PERF_CNT_EN
  logic [31:0]          BranchCnt;
  logic [31:0]          TakenCnt;

  modport master (
    output StallE, FlushE, BranchE, PCSrcE, RegWriteE, MemWriteE,
           FlagWriteE, CondE, LaneMaskE, ALUFlagsE,
    input  BranchTakenE, PCSrcECU, MemWriteECU, RegWriteECU, FlagsQ,
           BranchCnt, TakenCnt
  );

  modport slave (
    input  StallE, FlushE, BranchE, PCSrcE, RegWriteE, MemWriteE,
           FlagWriteE, CondE, LaneMaskE, ALUFlagsE,
    output BranchTakenE, PCSrcECU, MemWriteECU, RegWriteECU, FlagsQ,
           BranchCnt, TakenCnt
  );
`else
  modport master (
    output StallE, FlushE, BranchE, PCSrcE, RegWriteE, MemWriteE,
           FlagWriteE, CondE, LaneMaskE, ALUFlagsE,
    input  BranchTakenE, PCSrcECU, MemWriteECU, RegWriteECU, FlagsQ
  );

  modport slave (
    input  StallE, FlushE, BranchE, PCSrcE, RegWriteE, MemWriteE,
           FlagWriteE, CondE, LaneMaskE, ALUFlagsE,
    output BranchTakenE, PCSrcECU, MemWriteECU, RegWriteECU, FlagsQ
  );
`endif

endinterface

// File: rtl/cond_lane.sv
// One SIMD lane: its NZCV flag register and the condition result for the
// instruction currently in E.
module cond_lane
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  cond_e      i_cond,
  input  logic       i_upd_ok,
  input  logic [1:0] i_flag_write,
  input  flags_t     i_alu_flags,
  output flags_t     o_flags,
  output logic       o_cond_ex
);

  flags_t r_flags;
  logic   w_cond_ex;
  logic   w_en;

  // Condition uses the stored flags, so a failed conditional compare cannot set flags.
  assign w_cond_ex = cond_eval(i_cond, r_flags);
  assign w_en      = i_upd_ok & w_cond_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_en) begin
      if (i_flag_write[1]) begin
        r_flags[FLAG_N] <= i_alu_flags[FLAG_N];
        r_flags[FLAG_Z] <= i_alu_flags[FLAG_Z];
      end
      if (i_flag_write[0]) begin
        r_flags[FLAG_C] <= i_alu_flags[FLAG_C];
        r_flags[FLAG_V] <= i_alu_flags[FLAG_V];
      end
    end
  end

  assign o_flags   = r_flags;
  assign o_cond_ex = w_cond_ex;

endmodule

// File: rtl/simd_conditional_unit.sv
// Execute-stage conditional unit: per-lane NZCV flags, condition gating of control
// signals. Optional branch/taken counters are enabled by defining COND_PERF_CNT_EN.
module simd_conditional_unit
  import cond_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int FLAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  simd_conditional_unit_if.slave  bus
);

  logic [LANES-1:0] w_cond_ex;
  logic [LANES-1:0] w_upd_ok;
  logic             w_live;
  logic             w_move;
  cond_e            w_cond;

  assign w_cond = cond_e'(bus.CondE);
  assign w_move = ~bus.StallE & ~bus.FlushE;
  // Gated outputs are forced low during reset and for flushed bubbles.
  assign w_live = rst_n & ~bus.FlushE;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    if (gi == 0) begin : g_scalar
      // Scalar ops always target lane 0, so its mask bit is not consulted here.
      assign w_upd_ok[gi] = w_move;
    end else begin : g_vector
      assign w_upd_ok[gi] = w_move & bus.LaneMaskE[gi];
    end

    cond_lane u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cond       (w_cond),
      .i_upd_ok     (w_upd_ok[gi]),
      .i_flag_write (bus.FlagWriteE),
      .i_alu_flags  (bus.ALUFlagsE[gi*FLAG_W +: FLAG_W]),
      .o_flags      (bus.FlagsQ[gi*FLAG_W +: FLAG_W]),
      .o_cond_ex    (w_cond_ex[gi])
    );
  end

  assign bus.BranchTakenE = w_live & bus.BranchE   & w_cond_ex[0];
  assign bus.PCSrcECU     = w_live & bus.PCSrcE    & w_cond_ex[0];
  assign bus.MemWriteECU  = w_live & bus.MemWriteE & w_cond_ex[0];
  assign bus.RegWriteECU  = {LANES{w_live & bus.RegWriteE}} & w_cond_ex & bus.LaneMaskE;

`ifdef COND_PERF_CNT_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_taken_cnt;
  logic        w_br_evt;

  assign w_br_evt = bus.BranchE & w_move;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      if (w_br_evt && (r_branch_cnt != 32'hFFFF_FFFF)) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
      end
      if (w_br_evt && w_cond_ex[0] && (r_taken_cnt != 32'hFFFF_FFFF)) begin
        r_taken_cnt <= r_taken_cnt + 32'd1;
      end
    end
  end

  assign bus.BranchCnt = r_branch_cnt;
  assign bus.TakenCnt  = r_taken_cnt;
`endif

endmodule
